// File: rtl/i2c_cfg_arbiter.sv
// Round-robin arbiter sharing one I2C master between the MS7210 (port 0) and
// MS7200 (port 1) register-configuration sequencers, with a per-command watchdog.
module i2c_cfg_arbiter #(
    parameter logic [6:0]  SLV_ADDR0   = 7'h59,
    parameter logic [6:0]  SLV_ADDR1   = 7'h56,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_exec,
    input  logic [23:0] req0_data,
    input  logic        req0_rh_wl,
    output logic        req0_busy,
    output logic        req0_done,
    output logic [7:0]  req0_data_r,
    output logic        req0_err,
    input  logic        req1_exec,
    input  logic [23:0] req1_data,
    input  logic        req1_rh_wl,
    output logic        req1_busy,
    output logic        req1_done,
    output logic [7:0]  req1_data_r,
    output logic        req1_err,
    output logic        i2c_exec,
    output logic [23:0] i2c_data,
    output logic        i2c_rh_wl,
    output logic [6:0]  i2c_slv_addr,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_data_r,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state, state_nx;
    logic           pend0, pend1;
    logic [23:0]    hold0_data, hold1_data;
    logic           hold0_rw, hold1_rw;
    logic           grant, grant_nx;
    logic           last_grant;
    logic [WDW-1:0] wdog;
    logic           do_grant, finish, timed_out;
    logic           clear0, clear1, acc0, acc1;

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        grant_nx  = grant;
        do_grant  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (pend0 || pend1) begin
                    do_grant = 1'b1;
                    state_nx = ISSUE;
                    grant_nx = (pend0 && pend1) ? ~last_grant : pend1;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                // A done arriving on the terminal count still wins over the timeout.
                if (i2c_done) begin
                    finish   = 1'b1;
                    state_nx = DONE;
                end else if (wdog == WD_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: a new exec in the grantee's DONE cycle is accepted (set beats clear).
    assign clear0 = (state == DONE) && !grant;
    assign clear1 = (state == DONE) &&  grant;
    assign acc0   = req0_exec && (!pend0 || clear0);
    assign acc1   = req1_exec && (!pend1 || clear1);

    assign req0_busy = pend0;
    assign req1_busy = pend1;

    // NOTE: sequential state uses non-blocking assignments only, so update order never matters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 1'b0;
            last_grant   <= 1'b1;
            pend0        <= 1'b0;
            pend1        <= 1'b0;
            // NOTE: holding registers are cleared too, so no stale command survives a reset.
            hold0_data   <= '0;
            hold1_data   <= '0;
            hold0_rw     <= 1'b0;
            hold1_rw     <= 1'b0;
            wdog         <= '0;
            i2c_exec     <= 1'b0;
            i2c_data     <= '0;
            i2c_rh_wl    <= 1'b0;
            i2c_slv_addr <= SLV_ADDR0;
            req0_done    <= 1'b0;
            req0_data_r  <= '0;
            req0_err     <= 1'b0;
            req1_done    <= 1'b0;
            req1_data_r  <= '0;
            req1_err     <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            i2c_exec <= do_grant;

            if (do_grant) begin
                i2c_data     <= grant_nx ? hold1_data : hold0_data;
                i2c_rh_wl    <= grant_nx ? hold1_rw   : hold0_rw;
                i2c_slv_addr <= grant_nx ? SLV_ADDR1  : SLV_ADDR0;
            end

            if (state == ISSUE)
                wdog <= '0;
            else if (state == WAIT)
                wdog <= wdog + WDW'(1);

            if (acc0) begin
                pend0      <= 1'b1;
                hold0_data <= req0_data;
                hold0_rw   <= req0_rh_wl;
            end else if (clear0) begin
                pend0 <= 1'b0;
            end
            if (acc1) begin
                pend1      <= 1'b1;
                hold1_data <= req1_data;
                hold1_rw   <= req1_rh_wl;
            end else if (clear1) begin
                pend1 <= 1'b0;
            end
            if ((req0_exec && !acc0) || (req1_exec && !acc1))
                overrun <= 1'b1;

            req0_done <= finish && !grant;
            req1_done <= finish &&  grant;
            if (finish && !grant) begin
                req0_data_r <= timed_out ? 8'hFF : i2c_data_r;
                req0_err    <= timed_out;
            end
            if (finish && grant) begin
                req1_data_r <= timed_out ? 8'hFF : i2c_data_r;
                req1_err    <= timed_out;
            end
            if (timed_out)
                timeout_err <= 1'b1;

            if (state == DONE)
                last_grant <= grant;
        end
    end

endmodule
